cnn_layer_sequencer: RTL and testbench

//  Drives the CNN accelerator control handshake (start / same_w / finished / finished_ok) over N layers.

---
 rtl/cnn_seq_pkg.sv | 17 +
 rtl/cnn_layer_sequencer_if.sv | 25 ++
 rtl/cnn_seq_watchdog.sv | 38 +++
 rtl/cnn_layer_sequencer.sv | 141 ++++++++++++++
 tb/tb_cnn_layer_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_seq_pkg.sv
// Shared types and default sizes for the CNN layer sequencer.
package cnn_seq_pkg;

    localparam int MAX_LAYERS_DEF = 16;
    localparam int LAYER_W_DEF    = 5;
    localparam int TIMEOUT_W_DEF  = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_RUN,
        ST_ACK,
        ST_RELEASE,
        ST_ERR
    } cnn_seq_state_e;

endpackage

// File: rtl/cnn_layer_sequencer_if.sv
// Control conduit between the layer sequencer and the CNN accelerator.
// Handshake: start is a 1-cycle pulse (same_w valid with it); the accelerator later raises the
// finished level; the sequencer answers with a 1-cycle finished_ok and waits for finished to fall.
interface cnn_layer_sequencer_if;

    logic acc_start_o;
    logic acc_same_w_o;
    logic acc_finished_i;
    logic acc_finished_ok_o;

    modport master (
        output acc_start_o,
        output acc_same_w_o,
        output acc_finished_ok_o,
        input  acc_finished_i
    );

    modport slave (
        input  acc_start_o,
        input  acc_same_w_o,
        input  acc_finished_ok_o,
        output acc_finished_i
    );

endinterface

// File: rtl/cnn_seq_watchdog.sv
// Per-layer watchdog: counts cycles since the last clear; expires once limit cycles have elapsed.
module cnn_seq_watchdog
    import cnn_seq_pkg::*;
#(
    parameter int TIMEOUT_W = TIMEOUT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_i,
    input  logic                 enable_i,
    input  logic [TIMEOUT_W-1:0] limit_i,
    output logic                 expired_o
);

    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

    // Saturates so a disabled watchdog never wraps back to a small value.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + TIMEOUT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q holds elapsed cycles minus one, so expiry lands exactly limit cycles after the clear.
    assign expired_o = enable_i && (limit_i != '0) && (cnt_q >= (limit_i - TIMEOUT_W'(1)));

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Sequences N accelerator layers: launch, wait for finished, acknowledge, wait for release.
// Reports done or error (bad count, abort, watchdog).
module cnn_layer_sequencer
    import cnn_seq_pkg::*;
#(
    parameter int MAX_LAYERS = MAX_LAYERS_DEF,
    parameter int LAYER_W    = LAYER_W_DEF,
    parameter int TIMEOUT_W  = TIMEOUT_W_DEF
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    input  logic                  go_i,
    input  logic                  abort_i,
    input  logic [LAYER_W-1:0]    num_layers_i,
    input  logic [MAX_LAYERS-1:0] same_w_mask_i,
    input  logic [TIMEOUT_W-1:0]  timeout_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [LAYER_W-1:0]    layer_idx_o,
    output cnn_seq_state_e        state_o,
    cnn_layer_sequencer_if.master acc
);

    localparam int                 SEL_W   = $clog2(MAX_LAYERS);
    localparam logic [LAYER_W-1:0] MAX_CNT = LAYER_W'(MAX_LAYERS);

    cnn_seq_state_e        state_q, state_d;
    logic [LAYER_W-1:0]    count_q, count_d;
    logic [LAYER_W-1:0]    idx_q, idx_d;
    logic [MAX_LAYERS-1:0] mask_q, mask_d;
    logic                  error_q, error_d;
    logic                  done_q, done_d;
    logic                  run_armed_q, run_armed_d;
    logic                  count_ok;
    logic                  wd_clear;
    logic                  wd_enable;
    logic                  wd_expired;

    assign count_ok  = (num_layers_i != '0) && (num_layers_i <= MAX_CNT);
    assign wd_enable = (state_q == ST_RUN) || (state_q == ST_RELEASE);

    cnn_seq_watchdog #(.TIMEOUT_W(TIMEOUT_W)) u_watchdog (
        .clk       (clk_clk),
        .rst_n     (reset_reset_n),
        .clear_i   (wd_clear),
        .enable_i  (wd_enable),
        .limit_i   (timeout_i),
        .expired_o (wd_expired)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        idx_d       = idx_q;
        mask_d      = mask_q;
        error_d     = error_q;
        done_d      = 1'b0;
        // Low in the first RUN cycle, so a finished level left over from the last layer is ignored.
        run_armed_d = (state_q == ST_RUN);

        case (state_q)
            ST_IDLE: begin
                if (go_i) begin
                    error_d   = 1'b0;
                    count_d   = num_layers_i;
                    mask_d    = same_w_mask_i;
                    mask_d[0] = 1'b0;
                    idx_d     = '0;
                    state_d   = count_ok ? ST_LAUNCH : ST_ERR;
                end
            end
            ST_LAUNCH: state_d = ST_RUN;
            ST_RUN: begin
                if (run_armed_q && acc.acc_finished_i) begin
                    state_d = ST_ACK;
                end else if (wd_expired) begin
                    state_d = ST_ERR;
                end
            end
            ST_ACK: state_d = ST_RELEASE;
            ST_RELEASE: begin
                if (!acc.acc_finished_i) begin
                    if (idx_q == (count_q - LAYER_W'(1))) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + LAYER_W'(1);
                        state_d = ST_LAUNCH;
                    end
                end else if (wd_expired) begin
                    state_d = ST_ERR;
                end
            end
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (abort_i && (state_q != ST_IDLE) && (state_q != ST_ERR)) begin
            state_d = ST_ERR;
            idx_d   = idx_q;
            done_d  = 1'b0;
        end

        if (state_d == ST_ERR) begin
            error_d = 1'b1;
        end

        wd_clear = (state_d != state_q) && ((state_d == ST_RUN) || (state_d == ST_RELEASE));
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            idx_q       <= '0;
            mask_q      <= '0;
            error_q     <= 1'b0;
            done_q      <= 1'b0;
            run_armed_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            mask_q      <= mask_d;
            error_q     <= error_d;
            done_q      <= done_d;
            run_armed_q <= run_armed_d;
        end
    end

    assign busy_o                = (state_q != ST_IDLE);
    assign done_o                = done_q;
    assign error_o               = error_q;
    assign layer_idx_o           = idx_q;
    assign state_o               = state_q;
    assign acc.acc_start_o       = (state_q == ST_LAUNCH);
    assign acc.acc_same_w_o      = (state_q == ST_LAUNCH) && mask_q[idx_q[SEL_W-1:0]];
    assign acc.acc_finished_ok_o = (state_q == ST_ACK);

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Bench for cnn_layer_sequencer: table of full runs against a small accelerator model,
// plus directed sequences for watchdog, abort, stale finished and mid-run reset.
module tb_cnn_layer_sequencer;
  import cnn_seq_pkg::*;

  localparam int ML = 16;
  localparam int LW = 5;
  localparam int TW = 24;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          go = 1'b0;
  logic          abort = 1'b0;
  logic [LW-1:0] num_layers = '0;
  logic [ML-1:0] mask = '0;
  logic [TW-1:0] timeout = '0;
  logic          busy, done, error;
  logic [LW-1:0] idx;
  cnn_seq_state_e state;

  cnn_layer_sequencer_if acc_if ();

  cnn_layer_sequencer dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .go_i          (go),
    .abort_i       (abort),
    .num_layers_i  (num_layers),
    .same_w_mask_i (mask),
    .timeout_i     (timeout),
    .busy_o        (busy),
    .done_o        (done),
    .error_o       (error),
    .layer_idx_o   (idx),
    .state_o       (state),
    .acc           (acc_if)
  );

  // ---------------- accelerator model ----------------
  bit   acc_en = 1'b0;
  bit   acc_never = 1'b0;
  int   acc_delay = 1;
  int   acc_hold = 1;
  logic model_fin = 1'b0;
  logic manual_fin = 1'b0;
  int   amode = 0;
  int   acnt = 0;

  assign acc_if.acc_finished_i = acc_en ? model_fin : manual_fin;

  always @(negedge clk) begin
    if (!rst_n || !acc_en) begin
      model_fin = 1'b0;
      amode = 0;
      acnt = 0;
    end else begin
      case (amode)
        0: if (acc_if.acc_start_o) begin amode = 1; acnt = acc_delay; end
        1: if (!acc_never) begin
             if (acnt <= 1) begin model_fin = 1'b1; amode = 2; end
             else acnt--;
           end
        2: if (acc_if.acc_finished_ok_o) begin
             acnt = acc_hold;
             if (acc_hold == 0) begin model_fin = 1'b0; amode = 0; end
             else amode = 3;
           end
        3: if (acnt <= 1) begin model_fin = 1'b0; amode = 0; end
           else acnt--;
        default: amode = 0;
      endcase
    end
  end

  // ---------------- monitor ----------------
  int            start_cnt = 0;
  int            ok_cnt = 0;
  int            done_cnt = 0;
  int            incr_cnt = 0;
  logic [LW-1:0] prev_idx = '0;
  logic          obs_sw [256];
  logic          obs_fin [256];
  logic [LW-1:0] obs_idx [256];

  always @(negedge clk) begin
    if (acc_if.acc_start_o) begin
      obs_sw[start_cnt % 256]  = acc_if.acc_same_w_o;
      obs_fin[start_cnt % 256] = acc_if.acc_finished_i;
      obs_idx[start_cnt % 256] = idx;
      start_cnt++;
    end
    if (acc_if.acc_finished_ok_o) ok_cnt++;
    if (done) done_cnt++;
    if (idx == prev_idx + LW'(1)) incr_cnt++;
    prev_idx = idx;
  end

  // ---------------- scoreboard ----------------
  logic [0:0] exp_q [$];
  int tests_run = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic go_pulse(input logic [LW-1:0] n, input logic [ML-1:0] m);
    @(negedge clk);
    num_layers = n;
    mask = m;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k;
    k = 0;
    while (busy && k < budget) begin @(negedge clk); k++; end
    check(name, 32'(busy), 32'd0);
  endtask

  task automatic wait_state(input cnn_seq_state_e s, input int budget, input string name);
    int k;
    k = 0;
    while (state != s && k < budget) begin @(negedge clk); k++; end
    check(name, 32'(state), 32'(s));
  endtask

  task automatic wait_error(input int budget);
    int k;
    k = 0;
    while (!error && k < budget) begin @(negedge clk); k++; end
  endtask

  typedef struct {
    logic [LW-1:0] n;
    logic [ML-1:0] m;
    int            delay;
    int            hold;
    int            exp_starts;
    logic [ML-1:0] exp_sw;
    int            exp_done;
    logic          exp_err;
  } vec_t;

  task automatic run_vec(input vec_t v, input bit mid_go, input string tag);
    int bs, bo, bd, bi, j, exp_inc;
    logic [0:0] e;
    bs = start_cnt; bo = ok_cnt; bd = done_cnt; bi = incr_cnt;
    acc_en = 1'b1; acc_never = 1'b0; acc_delay = v.delay; acc_hold = v.hold;
    timeout = 24'd1000;
    exp_q.delete();
    for (int k = 0; k < v.exp_starts; k++) exp_q.push_back(v.exp_sw[k]);
    go_pulse(v.n, v.m);
    check({tag, "_err_after_go"}, 32'(error), 32'(v.exp_err));
    check({tag, "_start_after_go"}, 32'(acc_if.acc_start_o), 32'(!v.exp_err));
    if (mid_go) begin
      repeat (3) @(negedge clk);
      num_layers = 5'd1;
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
    end
    wait_idle(3000, {tag, "_busy_end"});
    repeat (2) @(negedge clk);
    exp_inc = (v.exp_starts > 0) ? v.exp_starts - 1 : 0;
    check({tag, "_starts"}, 32'(start_cnt - bs), 32'(v.exp_starts));
    check({tag, "_oks"}, 32'(ok_cnt - bo), 32'(v.exp_starts));
    check({tag, "_dones"}, 32'(done_cnt - bd), 32'(v.exp_done));
    check({tag, "_error"}, 32'(error), 32'(v.exp_err));
    check({tag, "_idx_incr"}, 32'(incr_cnt - bi), 32'(exp_inc));
    for (int k = 0; k < v.exp_starts; k++) begin
      j = (bs + k) % 256;
      e = exp_q.pop_front();
      check($sformatf("%s_same_w%0d", tag, k), 32'(obs_sw[j]), 32'(e));
      check($sformatf("%s_idx%0d", tag, k), 32'(obs_idx[j]), 32'(k));
      check($sformatf("%s_fin_low%0d", tag, k), 32'(obs_fin[j]), 32'd0);
    end
    if (!v.exp_err) check({tag, "_final_idx"}, 32'(idx), 32'(v.n) - 32'd1);
    acc_en = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs [7];

  initial begin
    int bo, bd, bs, t0, t1;
    vec_t v6;

    vecs[0] = '{5'd3,  16'h0006, 10, 1, 3,  16'h0006, 1, 1'b0};
    vecs[1] = '{5'd0,  16'h00FF, 3,  1, 0,  16'h0000, 0, 1'b1};
    vecs[2] = '{5'd1,  16'hFFFF, 2,  1, 1,  16'h0000, 1, 1'b0};
    vecs[3] = '{5'd17, 16'h0001, 2,  1, 0,  16'h0000, 0, 1'b1};
    vecs[4] = '{5'd16, 16'hAAAB, 1,  0, 16, 16'hAAAA, 1, 1'b0};
    vecs[5] = '{5'd31, 16'h0000, 2,  1, 0,  16'h0000, 0, 1'b1};
    vecs[6] = '{5'd4,  16'h0005, 3,  5, 4,  16'h0004, 1, 1'b0};

    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_idx", 32'(idx), 32'd0);
    check("rst_start", 32'(acc_if.acc_start_o), 32'd0);
    check("rst_ok", 32'(acc_if.acc_finished_ok_o), 32'd0);
    check("rst_state", 32'(state), 32'(ST_IDLE));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], (i == 6), $sformatf("vec%0d", i));

    // Watchdog in RUN: accelerator never finishes.
    bo = ok_cnt;
    acc_en = 1'b1; acc_never = 1'b1; timeout = 24'd50;
    go_pulse(5'd2, 16'h0000);
    wait_state(ST_RUN, 10, "wd_run_entry");
    t0 = cyc;
    wait_error(200);
    t1 = cyc;
    check("wd_run_latency", 32'(t1 - t0), 32'd50);
    check("wd_run_state", 32'(state), 32'(ST_ERR));
    @(negedge clk);
    check("wd_run_busy", 32'(busy), 32'd0);
    check("wd_run_error", 32'(error), 32'd1);
    check("wd_run_oks", 32'(ok_cnt - bo), 32'd0);
    acc_en = 1'b0; acc_never = 1'b0;
    @(negedge clk);

    // Watchdog in RELEASE: finished held far too long after finished_ok.
    bo = ok_cnt; bd = done_cnt;
    acc_en = 1'b1; acc_delay = 3; acc_hold = 1000; timeout = 24'd20;
    go_pulse(5'd2, 16'h0000);
    wait_state(ST_RELEASE, 50, "wd_rel_entry");
    t0 = cyc;
    wait_error(200);
    t1 = cyc;
    check("wd_rel_latency", 32'(t1 - t0), 32'd20);
    check("wd_rel_oks", 32'(ok_cnt - bo), 32'd1);
    check("wd_rel_dones", 32'(done_cnt - bd), 32'd0);
    acc_en = 1'b0;
    wait_idle(10, "wd_rel_idle");

    // Abort in the same cycle finished rises.
    bo = ok_cnt;
    timeout = '0; manual_fin = 1'b0;
    go_pulse(5'd2, 16'h0000);
    wait_state(ST_RUN, 10, "abort_run_entry");
    repeat (3) @(negedge clk);
    manual_fin = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_state", 32'(state), 32'(ST_ERR));
    check("abort_error", 32'(error), 32'd1);
    check("abort_ok", 32'(acc_if.acc_finished_ok_o), 32'd0);
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_oks", 32'(ok_cnt - bo), 32'd0);
    manual_fin = 1'b0;
    @(negedge clk);

    // Stale finished level at LAUNCH: accepted only after one full RUN cycle.
    bd = done_cnt;
    manual_fin = 1'b1;
    go_pulse(5'd1, 16'h0000);
    check("stale_launch", 32'(acc_if.acc_start_o), 32'd1);
    check("stale_err_cleared", 32'(error), 32'd0);
    @(negedge clk);
    check("stale_run", 32'(state), 32'(ST_RUN));
    @(negedge clk);
    check("stale_ignored", 32'(acc_if.acc_finished_ok_o), 32'd0);
    @(negedge clk);
    check("stale_ack", 32'(acc_if.acc_finished_ok_o), 32'd1);
    manual_fin = 1'b0;
    wait_idle(10, "stale_idle");
    @(negedge clk);
    check("stale_done", 32'(done_cnt - bd), 32'd1);

    // Reset during the second layer's RUN.
    acc_en = 1'b1; acc_delay = 10; acc_hold = 1; timeout = '0;
    go_pulse(5'd3, 16'h0006);
    bs = 0;
    while (!(state == ST_RUN && idx == 5'd1) && bs < 100) begin @(negedge clk); bs++; end
    check("rst_mid_reached", 32'(idx), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_idx", 32'(idx), 32'd0);
    check("rst_mid_state", 32'(state), 32'(ST_IDLE));
    check("rst_mid_start", 32'(acc_if.acc_start_o), 32'd0);
    check("rst_mid_same_w", 32'(acc_if.acc_same_w_o), 32'd0);
    check("rst_mid_ok", 32'(acc_if.acc_finished_ok_o), 32'd0);
    check("rst_mid_done_err", 32'({done, error}), 32'd0);
    acc_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    v6 = '{5'd2, 16'h0002, 2, 1, 2, 16'h0002, 1, 1'b0};
    run_vec(v6, 1'b0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "bench time limit");
  end

endmodule
